// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch front-end. It drives the ROM read port, captures
//            the returned words into a 2-entry FIFO and supports redirect/flush.
//            Optional stall counter: define INST_FETCH_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_enable,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef INST_FETCH_STALL_CNT_EN
  , output logic [15:0]     stall_count
`endif
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [ADDR_W-1:0] epc0_q, epc0_d, epc1_q, epc1_d;
  logic              w_pop, w_push, w_issue;
  logic [2:0]        w_occ;

  // rst_n gates issue so rom_en drops the moment reset asserts.
  always_comb begin
    w_pop   = (count_q != 2'd0) & inst_ready;
    w_push  = inflight_q & ~redirect_valid;
    w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue = rst_n & fetch_enable & ~redirect_valid & (w_occ < 3'd2);
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = w_issue;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (w_issue) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    epc0_d  = epc0_q;
    epc1_d  = epc1_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_d = rom_data;
            epc0_d  = req_pc_q;
          end else begin
            data1_d = rom_data;
            epc1_d  = req_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          data0_d = data1_q;
          epc0_d  = epc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_d = rom_data;
            epc0_d  = req_pc_q;
          end else begin
            data0_d = data1_q;
            epc0_d  = epc1_q;
            data1_d = rom_data;
            epc1_d  = req_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= C_RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      epc0_q     <= '0;
      epc1_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      epc0_q     <= epc0_d;
      epc1_q     <= epc1_d;
    end
  end

  assign rom_en     = w_issue;
  assign rom_addr   = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = data0_q;
  assign inst_pc    = epc0_q;

`ifdef INST_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (redirect_valid) begin
      stall_d = 16'd0;
    end else if (inst_valid && !inst_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed bench for inst_fetch with a transaction-level reference
//            model. It also checks stall_count when INST_FETCH_STALL_CNT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_enable;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
`ifdef INST_FETCH_STALL_CNT_EN
  logic [15:0]       stall_count;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  int scyc   = 0;

  inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable   (fetch_enable),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef INST_FETCH_STALL_CNT_EN
    , .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // ROM holds word i = i.
  always @(posedge clk) begin
    if (rom_en) rom_data <= DATA_W'(rom_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: every issued request is a transaction (pc, issue cycle) that
  // becomes visible two cycles after issue and leaves on accept or redirect.
  int q_pc[$];
  int q_cyc[$];
  int now;
  int m_pc;
  int m_stall;

  always @(negedge clk) begin
    bit exp_valid, pop, exp_en;
    if (!rst_n) begin
      q_pc.delete();
      q_cyc.delete();
      now     = 0;
      m_pc    = 0;
      m_stall = 0;
    end else begin
      exp_valid = (q_pc.size() > 0) && (q_cyc[0] <= now - 2);
      pop       = exp_valid && inst_ready;
      exp_en    = fetch_enable && !redirect_valid && ((q_pc.size() - int'(pop)) < 2);
      chk("m_rom_en", 32'(rom_en), 32'(exp_en));
      chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
      chk("m_inst_valid", 32'(inst_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("m_inst", inst, 32'(q_pc[0]));
        chk("m_inst_pc", 32'(inst_pc), 32'(q_pc[0]));
      end
`ifdef INST_FETCH_STALL_CNT_EN
      chk("m_stall_count", 32'(stall_count), 32'(m_stall));
`endif
      if (redirect_valid) begin
        q_pc.delete();
        q_cyc.delete();
        m_pc    = int'(redirect_addr);
        m_stall = 0;
      end else begin
        if (exp_valid && !inst_ready && m_stall < 65535) m_stall++;
        if (pop) begin
          void'(q_pc.pop_front());
          void'(q_cyc.pop_front());
        end
        if (exp_en) begin
          q_pc.push_back(m_pc);
          q_cyc.push_back(now);
          m_pc = (m_pc + 1) % (1 << ADDR_W);
        end
      end
      now++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic goto(input int c);
    while (scyc < c) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_enable = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scyc = 0;
    #1;
    chk("c0_rom_en", 32'(rom_en), 32'd1);
    chk("c0_rom_addr", 32'(rom_addr), 32'd0);
    goto(1); chk("c1_valid", 32'(inst_valid), 32'd0);
    goto(2); chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_inst", inst, 32'd0);
    chk("c2_inst_pc", 32'(inst_pc), 32'd0);
    goto(3); chk("c3_inst", inst, 32'd1);
    goto(4); chk("c4_inst", inst, 32'd2);
    goto(5); chk("c5_inst", inst, 32'd3);

    // Backpressure for 5 cycles while head is 4.
    goto(6); chk("c6_inst", inst, 32'd4);
    inst_ready = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      goto(c);
      chk("hold_inst", inst, 32'd4);
      chk("hold_valid", 32'(inst_valid), 32'd1);
    end
    chk("full_rom_en", 32'(rom_en), 32'd0);
    goto(11); inst_ready = 1'b1;
    chk("rel_inst4", inst, 32'd4);
    goto(12); chk("rel_inst5", inst, 32'd5);
    goto(13); chk("rel_inst6", inst, 32'd6);
    goto(14); chk("rel_inst7", inst, 32'd7);

    // Redirect while head is pc 10.
    goto(17); chk("pre_redir_pc", 32'(inst_pc), 32'd10);
    redirect_valid = 1'b1; redirect_addr = 7'h40;
    goto(18); redirect_valid = 1'b0;
    chk("redir_gap1", 32'(inst_valid), 32'd0);
    goto(19); chk("redir_gap2", 32'(inst_valid), 32'd0);
    goto(20); chk("redir_inst", inst, 32'h40);
    chk("redir_inst_pc", 32'(inst_pc), 32'h40);
    goto(21); chk("redir_next", 32'(inst_pc), 32'h41);

    // Redirect near the top of the address space.
    goto(22); redirect_valid = 1'b1; redirect_addr = 7'd126;
    goto(23); redirect_valid = 1'b0;
    goto(25); chk("wrap_126", 32'(inst_pc), 32'd126);
    goto(26); chk("wrap_127", 32'(inst_pc), 32'd127);
    goto(27); chk("wrap_0", 32'(inst_pc), 32'd0);
    chk("wrap_0_inst", inst, 32'd0);
    goto(28); chk("wrap_1", 32'(inst_pc), 32'd1);

    // Fetch disabled: drain only.
    goto(29); fetch_enable = 1'b0;
    goto(32); chk("dis_rom_en", 32'(rom_en), 32'd0);
    chk("dis_drained", 32'(inst_valid), 32'd0);
    goto(33); fetch_enable = 1'b1;

    // Asynchronous reset mid-stream.
    goto(40);
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_rom_en", 32'(rom_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scyc = 0;
    #1;
    chk("rr_c0_rom_addr", 32'(rom_addr), 32'd0);
    goto(2); chk("rr_c2_inst", inst, 32'd0);
    chk("rr_c2_valid", 32'(inst_valid), 32'd1);

    // Stall window then redirect.
    goto(4); inst_ready = 1'b0;
    goto(9);
`ifdef INST_FETCH_STALL_CNT_EN
    chk("stall_5", 32'(stall_count), 32'd5);
`endif
    chk("stall_head", inst, 32'd2);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 7'h10;
    goto(10); redirect_valid = 1'b0;
`ifdef INST_FETCH_STALL_CNT_EN
    chk("stall_clr", 32'(stall_count), 32'd0);
`endif
    goto(12); chk("post_inst", inst, 32'h10);
    goto(20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
